// File: rtl/pipe_ctrl.sv
// Pipeline-register controller: a DEPTH-deep chain of valid/payload/rd-tag stages with
// retire backpressure, load-use stall detection, youngest-first forwarding and selectable flush.
module pipe_ctrl #(
   parameter int DEPTH = 4,
   parameter int W     = 512,
   parameter int XLEN  = 32,
   parameter int SW    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            in_payload,
   input  logic [4:0]              in_rs1,
   input  logic [4:0]              in_rs2,
   input  logic [4:0]              in_rd,
   input  logic                    in_rd_we,
   input  logic [XLEN-1:0]         rf_rs1_data,
   input  logic [XLEN-1:0]         rf_rs2_data,
   output logic [XLEN-1:0]         fwd_rs1_data,
   output logic [XLEN-1:0]         fwd_rs2_data,
   input  logic [DEPTH*XLEN-1:0]   stage_result_i,
   input  logic [DEPTH-1:0]        stage_result_vld_i,
   input  logic                    halt_i,
   input  logic                    flush_i,
   input  logic [SW-1:0]           flush_stage_i,
   output logic [DEPTH-1:0]        st_valid_o,
   output logic [DEPTH*W-1:0]      st_payload_o,
   input  logic                    ret_ready_i,
   output logic [31:0]             stall_cnt_o,
   output logic [31:0]             flush_cnt_o,
   output logic [31:0]             retire_cnt_o
);

   typedef struct packed {
      logic         valid;
      logic         rd_we;
      logic [4:0]   rd;
      logic [W-1:0] payload;
   } stage_t;

   stage_t      st_q [DEPTH];
   stage_t      st_d [DEPTH];
   stage_t      incoming;

   logic        advance;
   logic        hazard1;
   logic        hazard2;
   logic        hazard;
   logic        accept;
   logic        retire;
   int          flush_at;

   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] retire_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
      return (en && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
   endfunction

   // A valid oldest stage that the consumer refuses blocks the whole chain.
   assign advance  = !halt_i && !(st_q[DEPTH-1].valid && !ret_ready_i);
   assign retire   = st_q[DEPTH-1].valid && ret_ready_i && !halt_i;
   assign flush_at = int'(flush_stage_i);

   always_comb begin
      hazard1      = 1'b0;
      hazard2      = 1'b0;
      fwd_rs1_data = rf_rs1_data;
      fwd_rs2_data = rf_rs2_data;
      // Walk oldest to youngest so the youngest matching stage is the one left standing.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (in_rs1 != 5'd0 && st_q[k].valid && st_q[k].rd_we && st_q[k].rd == in_rs1) begin
            hazard1      = !stage_result_vld_i[k];
            fwd_rs1_data = stage_result_vld_i[k] ? stage_result_i[k*XLEN +: XLEN] : rf_rs1_data;
         end
         if (in_rs2 != 5'd0 && st_q[k].valid && st_q[k].rd_we && st_q[k].rd == in_rs2) begin
            hazard2      = !stage_result_vld_i[k];
            fwd_rs2_data = stage_result_vld_i[k] ? stage_result_i[k*XLEN +: XLEN] : rf_rs2_data;
         end
      end
   end

   assign hazard   = hazard1 || hazard2;
   assign in_ready = reset && advance && !hazard && !flush_i;
   assign accept   = in_valid && in_ready;

   always_comb begin
      incoming.valid   = 1'b1;
      incoming.rd_we   = in_rd_we;
      incoming.rd      = in_rd;
      incoming.payload = in_payload;
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) st_d[k] = st_q[k];
      if (advance) begin
         st_d[0] = accept ? incoming : '0;
         for (int k = 1; k < DEPTH; k++) st_d[k] = st_q[k-1];
      end
      // The redirecting instruction survives; everything younger than it becomes a bubble.
      if (flush_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (k < flush_at || (advance && k == flush_at)) st_d[k] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: payloads are reset as well, since a bubble must decode as the all-zero instruction.
         for (int k = 0; k < DEPTH; k++) st_q[k] <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         // NOTE: non-blocking, so every stage captures its neighbour's pre-edge contents.
         for (int k = 0; k < DEPTH; k++) st_q[k] <= st_d[k];
         stall_cnt  <= sat_inc(stall_cnt, in_valid && hazard && !flush_i);
         flush_cnt  <= sat_inc(flush_cnt, flush_i);
         retire_cnt <= sat_inc(retire_cnt, retire);
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_out
      assign st_valid_o[k]          = st_q[k].valid;
      assign st_payload_o[k*W +: W] = st_q[k].payload;
   end

   assign stall_cnt_o  = stall_cnt;
   assign flush_cnt_o  = flush_cnt;
   assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, all checked every cycle
// against a slot-array model of the pipeline.
module tb_pipe_ctrl;
   localparam int DEPTH = 4;
   localparam int W     = 512;
   localparam int XLEN  = 32;
   localparam int SW    = 2;
   localparam longint CMAX = 64'hFFFF_FFFF;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          in_payload;
   logic [4:0]            in_rs1, in_rs2, in_rd;
   logic                  in_rd_we;
   logic [XLEN-1:0]       rf_rs1_data, rf_rs2_data;
   logic [XLEN-1:0]       fwd_rs1_data, fwd_rs2_data;
   logic [DEPTH*XLEN-1:0] stage_result_i;
   logic [DEPTH-1:0]      stage_result_vld_i;
   logic                  halt_i, flush_i;
   logic [SW-1:0]         flush_stage_i;
   logic [DEPTH-1:0]      st_valid_o;
   logic [DEPTH*W-1:0]    st_payload_o;
   logic                  ret_ready_i;
   logic [31:0]           stall_cnt_o, flush_cnt_o, retire_cnt_o;

   always #5 clk = ~clk;

   pipe_ctrl #(.DEPTH(DEPTH), .W(W), .XLEN(XLEN), .SW(SW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
      .stage_result_i(stage_result_i), .stage_result_vld_i(stage_result_vld_i),
      .halt_i(halt_i), .flush_i(flush_i), .flush_stage_i(flush_stage_i),
      .st_valid_o(st_valid_o), .st_payload_o(st_payload_o),
      .ret_ready_i(ret_ready_i),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .retire_cnt_o(retire_cnt_o)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Model: one slot per stage, index 0 youngest.
   bit               m_on = 1'b0;
   logic [DEPTH-1:0] m_v, m_we;
   logic [4:0]       m_rd [DEPTH];
   logic [W-1:0]     m_pl [DEPTH];
   longint           m_stall, m_flush, m_ret;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_pl(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic longint sat(input longint c);
      return (c > CMAX) ? CMAX : c;
   endfunction

   function automatic logic [W-1:0] pl_of(input logic [31:0] tag);
      return {(W/32){tag}};
   endfunction

   // Operand lookup: the first (youngest) slot writing rs decides; x0 never matches.
   function automatic void model_src(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                     output logic [XLEN-1:0] val, output bit haz);
      val = rf;
      haz = 1'b0;
      if (rs != 5'd0) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (m_v[k] && m_we[k] && m_rd[k] == rs) begin
               haz = !stage_result_vld_i[k];
               if (!haz) val = stage_result_i[k*XLEN +: XLEN];
               break;
            end
         end
      end
   endfunction

   // One clock: compare at the falling edge, then advance the model across the rising edge.
   task automatic cycle();
      logic [XLEN-1:0]  e1, e2;
      bit               h1, h2, adv, rdy, take;
      int               surv;
      logic [DEPTH-1:0] nv, nwe;
      logic [4:0]       nrd [DEPTH];
      logic [W-1:0]     npl [DEPTH];
      @(negedge clk);
      model_src(in_rs1, rf_rs1_data, e1, h1);
      model_src(in_rs2, rf_rs2_data, e2, h2);
      adv = !halt_i && !(m_v[DEPTH-1] && !ret_ready_i);
      rdy = reset && adv && !(h1 || h2) && !flush_i;
      if (m_on) begin
         check("in_ready", in_ready, rdy);
         if (!h1) check("fwd_rs1", fwd_rs1_data, e1);
         if (!h2) check("fwd_rs2", fwd_rs2_data, e2);
         check("st_valid", st_valid_o, m_v);
         for (int k = 0; k < DEPTH; k++)
            check_pl($sformatf("payload%0d", k), st_payload_o[k*W +: W], m_pl[k]);
         check("stall_cnt", stall_cnt_o, m_stall);
         check("flush_cnt", flush_cnt_o, m_flush);
         check("retire_cnt", retire_cnt_o, m_ret);
      end
      take = in_valid && rdy;
      for (int k = 0; k < DEPTH; k++) begin
         if (!adv) begin
            nv[k] = m_v[k]; nwe[k] = m_we[k]; nrd[k] = m_rd[k]; npl[k] = m_pl[k];
         end else if (k == 0) begin
            nv[0] = take; nwe[0] = take && in_rd_we;
            nrd[0] = take ? in_rd : 5'd0; npl[0] = take ? in_payload : '0;
         end else begin
            nv[k] = m_v[k-1]; nwe[k] = m_we[k-1]; nrd[k] = m_rd[k-1]; npl[k] = m_pl[k-1];
         end
      end
      // After the edge the surviving instruction sits at surv; all younger slots are empty.
      surv = adv ? int'(flush_stage_i) + 1 : int'(flush_stage_i);
      for (int k = 0; k < DEPTH; k++) begin
         if (!reset || (flush_i && k < surv)) begin
            nv[k] = 1'b0; nwe[k] = 1'b0; nrd[k] = 5'd0; npl[k] = '0;
         end
      end
      if (!reset) begin
         m_stall = 0; m_flush = 0; m_ret = 0;
      end else begin
         if (in_valid && (h1 || h2) && !flush_i) m_stall = sat(m_stall + 1);
         if (flush_i) m_flush = sat(m_flush + 1);
         if (m_v[DEPTH-1] && ret_ready_i && !halt_i) m_ret = sat(m_ret + 1);
      end
      @(posedge clk);
      m_v = nv; m_we = nwe;
      for (int k = 0; k < DEPTH; k++) begin
         m_rd[k] = nrd[k]; m_pl[k] = npl[k];
      end
      m_on = 1'b1;
      #1;
   endtask

   task automatic idle();
      reset = 1'b1; in_valid = 1'b0; in_payload = '0;
      in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b0;
      rf_rs1_data = 32'h0101_0101; rf_rs2_data = 32'h0202_0202;
      stage_result_i = '0; stage_result_vld_i = '1;
      halt_i = 1'b0; flush_i = 1'b0; flush_stage_i = '0; ret_ready_i = 1'b1;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < DEPTH + 1; i++) cycle();
   endtask

   task automatic issue(input logic [31:0] tag, input logic [4:0] rd, input logic we);
      in_valid = 1'b1; in_payload = pl_of(tag);
      in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = rd; in_rd_we = we;
      cycle();
      in_valid = 1'b0;
   endtask

   longint base;

   initial begin
      idle();
      // Reset held with an instruction offered.
      reset = 1'b0; in_valid = 1'b1; in_payload = pl_of(32'hAAAA_0001);
      for (int i = 0; i < 3; i++) cycle();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_st_valid", st_valid_o, 4'b0000);
      check("rst_stall", stall_cnt_o, 0);
      check("rst_flush", flush_cnt_o, 0);
      check("rst_retire", retire_cnt_o, 0);

      // Latency: accepted instruction reaches the oldest stage after DEPTH edges.
      idle();
      issue(32'hA0A0_0001, 5'd0, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) cycle();
      check("lat_valid", st_valid_o, 4'b1000);
      check("lat_payload", st_payload_o[3*W +: 32], 32'hA0A0_0001);
      drain();

      // Load-use hazard, then forwarding once the result lands.
      issue(32'hB0B0_0005, 5'd5, 1'b1);
      in_valid = 1'b1; in_payload = pl_of(32'hB0B0_0006);
      in_rs1 = 5'd5; in_rd = 5'd6; in_rd_we = 1'b0; stage_result_vld_i = '0;
      #1 check("haz_in_ready", in_ready, 1'b0);
      cycle();
      check("haz_bubble", st_valid_o[1:0], 2'b10);
      check("haz_stall_cnt", stall_cnt_o, 1);
      stage_result_vld_i = 4'b0010;
      stage_result_i[1*XLEN +: XLEN] = 32'hDEAD_BEEF;
      #1 check("haz_fwd", fwd_rs1_data, 32'hDEAD_BEEF);
      check("haz_ready_again", in_ready, 1'b1);
      cycle();
      check("haz_accepted", st_payload_o[31:0], 32'hB0B0_0006);
      check("haz_stall_hold", stall_cnt_o, 1);
      drain();

      // Youngest-first forwarding and the x0 rule.
      issue(32'hC0C0_0001, 5'd3, 1'b1);
      issue(32'hC0C0_0002, 5'd0, 1'b1);
      issue(32'hC0C0_0003, 5'd3, 1'b1);
      in_rs1 = 5'd0; in_rs2 = 5'd3;
      rf_rs1_data = 32'hCAFE_0001; rf_rs2_data = 32'h5555_AAAA;
      stage_result_i[0*XLEN +: XLEN] = 32'h11;
      stage_result_i[1*XLEN +: XLEN] = 32'h33;
      stage_result_i[2*XLEN +: XLEN] = 32'h22;
      stage_result_vld_i = 4'b1101;
      #1 check("young_fwd_rs2", fwd_rs2_data, 32'h11);
      check("x0_fwd_rs1", fwd_rs1_data, 32'hCAFE_0001);
      check("x0_no_hazard", in_ready, 1'b1);
      cycle();
      drain();

      // Flush at stage 2, advancing then halted.
      for (int i = 0; i < DEPTH; i++) issue(32'hF0F0_0000 + i, 5'd0, 1'b0);
      flush_i = 1'b1; flush_stage_i = 2'd2;
      cycle();
      check("flush_adv_valid", st_valid_o, 4'b1000);
      check("flush_adv_surv", st_payload_o[3*W +: 32], 32'hF0F0_0001);
      check_pl("flush_bubble_zero", st_payload_o[0 +: W], '0);
      check("flush_cnt1", flush_cnt_o, 1);
      drain();
      for (int i = 0; i < DEPTH; i++) issue(32'hE0E0_0000 + i, 5'd0, 1'b0);
      flush_i = 1'b1; flush_stage_i = 2'd2; halt_i = 1'b1;
      cycle();
      check("flush_halt_valid", st_valid_o, 4'b1100);
      check("flush_halt_surv", st_payload_o[2*W +: 32], 32'hE0E0_0001);
      check("flush_cnt2", flush_cnt_o, 2);
      drain();

      // Retire backpressure.
      for (int i = 0; i < DEPTH; i++) issue(32'hD0D0_0000 + i, 5'd0, 1'b0);
      base = m_ret;
      ret_ready_i = 1'b0; in_valid = 1'b1; in_payload = pl_of(32'hD0D0_00FF);
      for (int i = 0; i < 5; i++) begin
         #1 check("bp_in_ready", in_ready, 1'b0);
         cycle();
         check("bp_hold", st_valid_o, 4'b1111);
         check("bp_retire", retire_cnt_o, base);
      end
      ret_ready_i = 1'b1; in_valid = 1'b0;
      cycle();
      check("bp_release", retire_cnt_o, base + 1);
      drain();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) != 0);
         in_valid = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < W / 32; i++) in_payload[i*32 +: 32] = $urandom;
         in_rs1 = 5'($urandom_range(0, 7));
         in_rs2 = 5'($urandom_range(0, 7));
         in_rd = 5'($urandom_range(0, 7));
         in_rd_we = 1'($urandom);
         rf_rs1_data = $urandom; rf_rs2_data = $urandom;
         for (int k = 0; k < DEPTH; k++) stage_result_i[k*XLEN +: XLEN] = $urandom;
         stage_result_vld_i = DEPTH'($urandom);
         halt_i = ($urandom_range(0, 9) == 0);
         flush_i = ($urandom_range(0, 9) == 0);
         flush_stage_i = SW'($urandom);
         ret_ready_i = ($urandom_range(0, 4) != 0);
         cycle();
      end
      drain();

      // Counter saturation.
      for (int i = 0; i < 3; i++) issue(32'h5A5A_0000 + i, 5'd0, 1'b0);
      force dut.retire_cnt = 32'hFFFF_FFFE;
      #1 release dut.retire_cnt;
      m_ret = 64'hFFFF_FFFE;
      cycle();
      cycle();
      check("sat_first", retire_cnt_o, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) cycle();
      check("sat_hold", retire_cnt_o, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline-register controller for the riscv32i core.
- Replaces the fixed set of 512-bit pipe registers, each with its own hand-wired flush, with a chain of DEPTH stage registers.
- Each stage carries a valid bit, a payload, and destination-register tags.
- Adds what the fixed core lacks: backpressure from the retire stage, load-use stall detection, youngest-first operand forwarding, flush at a selectable stage, and saturating performance counters.

Parameters:
- DEPTH, 4: number of stage registers after decode; stage 0 is youngest, DEPTH-1 is oldest (retire).
- W, 512: payload width per stage.
- XLEN, 32: register data width.
- SW, 2: width of flush_stage_i; must satisfy 2**SW >= DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_payload  in  W  decoded instruction bundle.
- in_rs1, in_rs2, in_rd  in  5 each  register indices.
- in_rd_we  in  1  instruction writes rd.
- rf_rs1_data, rf_rs2_data  in  XLEN each  register-file read data.
- fwd_rs1_data, fwd_rs2_data  out  XLEN each  forwarded operands, combinational.
- stage_result_i  in  DEPTH*XLEN  per-stage result; slice k is stage k.
- stage_result_vld_i  in  DEPTH  result in stage k is available.
- halt_i  in  1  freeze all stages.
- flush_i  in  1  kill stages younger than flush_stage_i.
- flush_stage_i  in  SW  stage holding the redirecting branch/jump.
- st_valid_o  out  DEPTH  per-stage valid.
- st_payload_o  out  DEPTH*W  per-stage payload.
- ret_ready_i  in  1  consumer accepts stage DEPTH-1 (e.g. data memory available).
- stall_cnt_o, flush_cnt_o, retire_cnt_o  out  32 each  performance counters.

Behaviour:
- Reset (reset==0 at posedge): all st_valid, payloads, rd tags and counters go to 0. in_ready is 0 while reset==0. Reset overrides halt and flush.
- advance = !halt_i && !(st_valid[DEPTH-1] && !ret_ready_i).
- hazard, per source rs in {in_rs1, in_rs2} with rs != 0:
  - Find the youngest stage k (lowest index) with st_valid[k], rd_we[k] and rd[k]==rs.
  - If it exists and stage_result_vld_i[k]==0, raise hazard (load-use).
  - Only the youngest match is considered; older matches are ignored.
- fwd_rsX_data:
  - Youngest match with result valid: stage_result_i slice k.
  - No match, or rs==0: rf_rsX_data.
  - The x0 rule applies even if some stage holds rd==0 with rd_we set.
- in_ready = advance && !hazard && !flush_i. Combinational; it must not depend on in_valid.
- At posedge when advance:
  - st[k] <= st[k-1] for k >= 1.
  - st[0] <= the incoming instruction if accepted, otherwise a bubble (valid 0, payload 0, rd_we 0).
- When !advance: all stages hold.
- Flush with F = flush_stage_i:
  - The instruction in stage F survives.
  - With advance: new stages 0..F become bubbles and stages above F shift normally.
  - Without advance: stages 0..F-1 become bubbles in place.
  - F==0 kills only the incoming instruction.
  - Flush and hazard in the same cycle: flush wins and the hazard stall is not counted.
- Retire: occurs when st_valid[DEPTH-1] && ret_ready_i && !halt_i.
- Counters increment by 1 per cycle and saturate at 0xFFFFFFFF (no wrap):
  - stall_cnt_o: in_valid && hazard && !flush_i.
  - flush_cnt_o: flush_i.
  - retire_cnt_o: each retire.
- Latency: an accepted instruction reaches stage DEPTH-1 after DEPTH edges, with no stalls.
- Payload bubbles are all-zero, as required by downstream decoding of the zero instruction.

Test Plan:
- Reset held low 3 cycles with in_valid=1 → st_valid=0000, in_ready=0, counters 0; after release, first instruction appears in stage 3 after 4 edges.
- Hazard: stage0 holds rd=5, rd_we=1, stage_result_vld_i[0]=0; offer rs1=5 → in_ready=0, stage0 becomes a bubble next edge, stall_cnt=1. Then set vld=1 with result 0xDEADBEEF → fwd_rs1_data=0xDEADBEEF and the instruction is accepted.
- Youngest-first: stage0 rd=3 result 0x11 and stage2 rd=3 result 0x22, both valid; rs2=3 → fwd_rs2_data=0x11. rs1=0 with stage1 rd=0 → rf_rs1_data passes through.
- Flush: all 4 stages valid, flush_i=1, flush_stage_i=2, advance=1 → next st_valid=1000 (stage3 holds the old stage2); flush_cnt=1. Same with halt_i=1 → st_valid=1100.
- Backpressure: stage3 valid, ret_ready_i=0 for 5 cycles → all stages hold, in_ready=0, retire_cnt unchanged. Release → retire_cnt +1.
- Saturation: force retire_cnt to 0xFFFFFFFE, retire 3 instructions → counter reads 0xFFFFFFFF.
